result_drain: RTL and testbench

- Downstream of the TPU core and its output global buffer.
- On the TPU's done pulse, it takes over the output buffer's read port and reads result words index 0..m-1, one packed output row per word.
- Streams them to the host/testbench over a valid/ready interface, with a small FIFO absorbing buffer read latency under backpressure.
- Releases the buffer and pulses drain_done when the last word has been accepted.

---
 rtl/result_drain_pkg.sv | 29 ++
 rtl/result_drain_if.sv | 12 +
 rtl/result_drain_fifo.sv | 57 +++++
 rtl/result_drain.sv | 150 +++++++++++++++
 tb/tb_result_drain.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_drain_pkg.sv
// result_drain_pkg: shared widths, FSM state encoding and parameter defaults
// for the result drain. DATA_SIZE/WORD_SIZE fall back to 8 when the buffer
// defines have not been provided by the build.
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package result_drain_pkg;
  localparam int DATA_W         = `DATA_SIZE;
  localparam int WORD_W         = `WORD_SIZE;
  localparam int RD_LAT_DEF     = 1;
  localparam int FIFO_DEPTH_DEF = 2;
  localparam int BASE_IDX_DEF   = 0;

  // state     | meaning
  // ST_IDLE   | waiting for a tpu_done rising edge
  // ST_READ   | owns the buffer, issuing one read per credit
  // ST_FLUSH  | all reads issued; waiting for in-flight data and the last word
  // ST_FINISH | one cycle before the registered drain_done pulse
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FINISH = 2'd3
  } drain_state_e;
endpackage

// File: rtl/result_drain_if.sv
// result_drain_if: valid/ready result stream from the drain to the host sink.
interface result_drain_if #(
  parameter int W = `WORD_SIZE
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/result_drain_fifo.sv
// drain_fifo: small synchronous FIFO with an occupancy count and a last flag
// stored alongside each data word. Push on full is only accepted together
// with a pop, so the count never exceeds DEPTH.
module drain_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       last_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic                       last_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  data_q [DEPTH];
  logic [DEPTH-1:0] last_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full || do_pop);

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        data_q[wr_ptr_q] <= data_i;
        last_q[wr_ptr_q] <= last_i;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign data_o  = data_q[rd_ptr_q];
  assign last_o  = last_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/result_drain.sv
// result_drain: on a tpu_done rising edge, reads rows 0..m-1 from the output
// buffer and streams them out over valid/ready through a skid FIFO. Reads are
// credited against FIFO space (counting a same-cycle pop) so a capture never
// lands in a full FIFO. Define DRAIN_CSUM_EN to add csum_o, the running XOR
// of accepted words for the current drain.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int BASE_IDX   = BASE_IDX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tpu_done_i,
  input  logic [3:0]        m_i,
  output logic              buf_sel_o,
  output logic              buf_wr_en_o,
  output logic [DATA_W-1:0] buf_index_o,
  input  logic [WORD_W-1:0] buf_data_i,
  result_drain_if.master    out_if,
  output logic              busy_o,
  output logic              drain_done_o
`ifdef DRAIN_CSUM_EN
  ,
  output logic [WORD_W-1:0] csum_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  drain_state_e      state_q, state_d;
  logic [3:0]        m_q, m_d, rd_cnt_q, rd_cnt_d;
  logic              done_prev_q, drain_done_q;
  logic [RD_LAT-1:0] pvld_q, pvld_d, plast_q, plast_d;
  logic              start, issue, issue_last, pop, fifo_last;
  logic [CW-1:0]     fifo_count;
  logic [WORD_W-1:0] fifo_data;
  logic [7:0]        inflight, credit_used;

  assign start = tpu_done_i && !done_prev_q && (state_q == ST_IDLE);
  assign pop   = out_if.valid && out_if.ready;

  // Reads issued but not yet captured into the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 8'(pvld_q[i]);
  end

  assign credit_used = 8'(fifo_count) + inflight - 8'(pop);

  // Next-state logic and read issue.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    rd_cnt_d   = rd_cnt_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d      = m_i;
          rd_cnt_d = '0;
          state_d  = (m_i == '0) ? ST_FINISH : ST_READ;
        end
      end
      ST_READ: begin
        if (credit_used < 8'(FIFO_DEPTH)) begin
          issue      = 1'b1;
          issue_last = (rd_cnt_q == m_q - 4'd1);
          if (issue_last) state_d = ST_FLUSH;
          else            rd_cnt_d = rd_cnt_q + 4'd1;
        end
      end
      ST_FLUSH: begin
        if (pop && fifo_last) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Read-valid shift pipe matching the buffer read latency.
  always_comb begin
    pvld_d     = '0;
    plast_d    = '0;
    pvld_d[0]  = issue;
    plast_d[0] = issue_last;
    for (int i = 1; i < RD_LAT; i++) begin
      pvld_d[i]  = pvld_q[i-1];
      plast_d[i] = plast_q[i-1];
    end
  end

  // State, counters, edge detector and read pipe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      m_q          <= '0;
      rd_cnt_q     <= '0;
      done_prev_q  <= 1'b0;
      drain_done_q <= 1'b0;
      pvld_q       <= '0;
      plast_q      <= '0;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      rd_cnt_q     <= rd_cnt_d;
      done_prev_q  <= tpu_done_i;
      drain_done_q <= (state_q == ST_FINISH);
      pvld_q       <= pvld_d;
      plast_q      <= plast_d;
    end
  end

  drain_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (pvld_q[RD_LAT-1]),
    .data_i  (buf_data_i),
    .last_i  (plast_q[RD_LAT-1]),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .last_o  (fifo_last),
    .count_o (fifo_count)
  );

  assign out_if.valid = (fifo_count != '0);
  assign out_if.data  = fifo_data;
  assign out_if.last  = fifo_last;

  // The buffer is held until the last in-flight read has returned.
  assign buf_sel_o    = (state_q == ST_READ) || ((state_q == ST_FLUSH) && (inflight != '0));
  assign buf_wr_en_o  = 1'b0;
  assign buf_index_o  = buf_sel_o ? (DATA_W'(BASE_IDX) + DATA_W'(rd_cnt_q)) : '0;
  assign busy_o       = (state_q == ST_READ) || (state_q == ST_FLUSH);
  assign drain_done_o = drain_done_q;

`ifdef DRAIN_CSUM_EN
  logic [WORD_W-1:0] csum_q;

  // Running XOR of accepted words, cleared when a drain starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     csum_q <= '0;
    else if (start) csum_q <= '0;
    else if (pop)   csum_q <= csum_q ^ fifo_data;
  end

  assign csum_o = csum_q;
`endif
endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: randomized and directed drains with a scoreboard queue of
// expected rows and a negedge monitor that checks every accepted word.
module tb_result_drain;
  import result_drain_pkg::*;

  localparam int RD_LAT     = RD_LAT_DEF;
  localparam int FIFO_DEPTH = FIFO_DEPTH_DEF;
  localparam int BASE_IDX   = 0;
  localparam int R_ONE = 0, R_TOGGLE = 1, R_RAND = 2, R_ZERO = 3;

  typedef struct {
    logic [WORD_W-1:0] d;
    logic              l;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              tpu_done = 1'b0;
  logic [3:0]        m_in = '0;
  logic              buf_sel, buf_wr_en, busy, drain_done;
  logic [DATA_W-1:0] buf_index;
  logic [WORD_W-1:0] buf_data;
`ifdef DRAIN_CSUM_EN
  logic [WORD_W-1:0] csum;
`endif

  result_drain_if #(.W(WORD_W)) sif ();

  result_drain #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .BASE_IDX(BASE_IDX)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tpu_done_i   (tpu_done),
    .m_i          (m_in),
    .buf_sel_o    (buf_sel),
    .buf_wr_en_o  (buf_wr_en),
    .buf_index_o  (buf_index),
    .buf_data_i   (buf_data),
    .out_if       (sif.master),
    .busy_o       (busy),
    .drain_done_o (drain_done)
`ifdef DRAIN_CSUM_EN
    ,
    .csum_o       (csum)
`endif
  );

  always #5 clk = ~clk;

  // Output buffer model: registered read with RD_LAT cycles of latency.
  logic [WORD_W-1:0] mem [256];
  logic [WORD_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[buf_index];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign buf_data = rd_pipe[RD_LAT-1];

  int   n_chk = 0;
  int   n_fail = 0;
  int   rdy_mode = R_ONE;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sink ready pattern, updated just after each rising edge.
  initial begin
    sif.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        R_ONE:    sif.ready = 1'b1;
        R_TOGGLE: sif.ready = ~sif.ready;
        R_RAND:   sif.ready = 1'($urandom_range(0, 1));
        default:  sif.ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks hold stability.
  logic              hold_v = 1'b0;
  logic [WORD_W-1:0] hold_d;
  logic              hold_l;
  exp_t              mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", sif.valid, 1);
        check("hold_data", sif.data, hold_d);
        check("hold_last", sif.last, hold_l);
      end
      if (buf_sel) check("wr_en_low", buf_wr_en, 0);
      if (sif.valid && sif.ready) begin
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("word_data", sif.data, mon_e.d);
          check("word_last", sif.last, mon_e.l);
        end
      end
      hold_v = sif.valid && !sif.ready;
      hold_d = sif.data;
      hold_l = sif.last;
    end
  end

  task automatic fill_rows(input int m);
    for (int i = 0; i < m; i++) mem[BASE_IDX + i] = WORD_W'($urandom);
  endtask

  task automatic start_drain(input int m);
    exp_t e;
    for (int i = 0; i < m; i++) begin
      e.d = mem[BASE_IDX + i];
      e.l = (i == m - 1);
      exp_q.push_back(e);
    end
    m_in = 4'(m);
    @(posedge clk);
    #2 tpu_done = 1'b1;
    @(posedge clk);
    #2 tpu_done = 1'b0;
    m_in = 4'($urandom);
  endtask

  task automatic run_drain(input int m, input int mode, input bit chk_timing, input bit poke);
    int first_v = -1, done_c = -1, sel_low = -1, max_idx = 0;
    bit saw_v = 0, saw_sel = 0;
    logic [WORD_W-1:0] x = '0;
    for (int i = 0; i < m; i++) x = x ^ mem[BASE_IDX + i];
    rdy_mode = mode;
    start_drain(m);
    for (int cyc = 0; cyc < 300 && done_c < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check("busy_start", busy, (m != 0));
      if (sif.valid) begin
        saw_v = 1;
        if (first_v < 0) first_v = cyc;
      end
      if (buf_sel) begin
        saw_sel = 1;
        if (buf_index > max_idx) max_idx = buf_index;
      end else if (saw_sel && sel_low < 0) begin
        sel_low = cyc;
      end
      if (mode == R_ZERO && cyc == 9) begin
        check("stall_sel", buf_sel, 1);
        check("stall_index", buf_index, BASE_IDX + FIFO_DEPTH);
        check("stall_valid", sif.valid, 1);
        rdy_mode = R_ONE;
      end
      if (poke && cyc == 3) begin
        tpu_done = 1'b1;
        m_in = 4'($urandom_range(1, 15));
      end
      if (poke && cyc == 4) tpu_done = 1'b0;
      if (drain_done) begin
        done_c = cyc;
        check("busy_at_done", busy, 0);
        check("queue_drained", exp_q.size(), 0);
`ifdef DRAIN_CSUM_EN
        check("csum", csum, x);
`endif
      end
    end
    check("done_seen", (done_c >= 0), 1);
    if (done_c < 0) exp_q.delete();
    else begin
      @(negedge clk);
      check("done_pulse_width", drain_done, 0);
    end
    if (m > 0) check("max_index", (max_idx <= BASE_IDX + m - 1), 1);
    else begin
      check("m0_no_valid", saw_v, 0);
      check("m0_no_sel", saw_sel, 0);
    end
    if (chk_timing) begin
      check("done_cycle", done_c, (m == 0) ? 1 : m + RD_LAT + 2);
      if (m > 0) begin
        check("first_valid", first_v, RD_LAT + 1);
        check("sel_before_done", (sel_low >= 0 && sel_low < done_c), 1);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, sif.valid, 0);
    check({tag, "_data"}, sif.data, 0);
    check({tag, "_last"}, sif.last, 0);
    check({tag, "_buf_sel"}, buf_sel, 0);
    check({tag, "_buf_index"}, buf_index, 0);
    check({tag, "_wr_en"}, buf_wr_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, drain_done, 0);
`ifdef DRAIN_CSUM_EN
    check({tag, "_csum"}, csum, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Full throughput, fixed rows 0x11..0x55.
    for (int i = 0; i < 5; i++) mem[BASE_IDX + i] = WORD_W'((i + 1) * 8'h11);
    run_drain(5, R_ONE, 1, 0);

    // Alternating backpressure.
    fill_rows(4);
    run_drain(4, R_TOGGLE, 0, 0);

    // Ten-cycle stall: only FIFO_DEPTH reads may be outstanding.
    fill_rows(3);
    run_drain(3, R_ZERO, 0, 0);

    // Empty drain.
    run_drain(0, R_ONE, 1, 0);

    // Reset while the third word is on the bus.
    fill_rows(5);
    rdy_mode = R_ONE;
    start_drain(5);
    repeat (5) @(negedge clk);
    check("pre_rst_valid", sif.valid, 1);
    check("pre_rst_data", sif.data, mem[BASE_IDX + 2]);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    fill_rows(5);
    run_drain(5, R_ONE, 1, 0);

    // Checksum pattern: 0xF0 ^ 0x0F ^ 0xFF = 0, then 0xAA alone.
    mem[BASE_IDX + 0] = WORD_W'(8'hF0);
    mem[BASE_IDX + 1] = WORD_W'(8'h0F);
    mem[BASE_IDX + 2] = WORD_W'(8'hFF);
    run_drain(3, R_ONE, 1, 0);
    mem[BASE_IDX + 0] = WORD_W'(8'hAA);
    run_drain(1, R_ONE, 1, 0);

    // Random lengths, data and backpressure, with ignored done edges mid-drain.
    for (int k = 0; k < 8; k++) begin
      int m;
      m = $urandom_range(1, 15);
      fill_rows(m);
      run_drain(m, (k % 2 == 0) ? R_RAND : R_TOGGLE, 0, (m >= 6));
    end
    fill_rows(15);
    run_drain(15, R_ONE, 1, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
